// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_cmd_sequencer
// Desc   : Buffers {func, data, last} commands in a FIFO and issues them to an
//          accumulator ALU datapath at one op per clock. Once the command
//          marked last has executed, the register value is presented as a
//          result with a valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int DEPTH        = 4,
  parameter bit CLR_ON_START = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset_b,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_func,
  input  logic [3:0] cmd_data,
  input  logic       cmd_last,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [2:0] alu_func,
  output logic [3:0] alu_data,
  output logic       alu_clr_b,
  input  logic [7:0] alu_q,
  output logic       busy,
  output logic [7:0] op_cnt
);

  localparam int         ADDR_W    = $clog2(DEPTH);
  localparam logic [2:0] FUNC_HOLD = 3'b111;
  localparam logic [7:0] CNT_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t              r_state;
  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic [7:0]          r_op_cnt;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [7:0]          w_head;   // {last, func[2:0], data[3:0]}

  assign w_full    = (r_count == (ADDR_W + 1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign cmd_ready = Reset_b & ~w_full;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_pop     = (r_state == ST_EXEC) & ~w_empty;
  assign op_cnt    = r_op_cnt;
  // The register only changes under EXEC ops or CLEAR, so it is stable in RESULT
  assign res_data  = alu_q;

  // Command storage; occupancy gates every read, so contents need no reset
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_last, cmd_func, cmd_data};
    end
  end

  // FIFO pointers (wrap naturally at power-of-two depth) and occupancy
  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Program sequencing: IDLE -> (CLEAR) -> EXEC ... -> RESULT -> IDLE
  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      r_state  <= ST_IDLE;
      r_op_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_op_cnt <= 8'd0;
            r_state  <= CLR_ON_START ? ST_CLEAR : ST_EXEC;
          end
        end
        ST_CLEAR: begin
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!w_empty) begin
            if (r_op_cnt != CNT_MAX) r_op_cnt <= r_op_cnt + 8'd1;
            if (w_head[7]) r_state <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (res_ready) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath and handshake outputs decoded from registered state and FIFO head
  always_comb begin
    alu_func  = FUNC_HOLD;
    alu_data  = 4'd0;
    alu_clr_b = 1'b1;
    res_valid = 1'b0;
    busy      = (r_state != ST_IDLE);
    if (!Reset_b) begin
      alu_clr_b = 1'b0;
      busy      = 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          alu_clr_b = 1'b0;
        end
        ST_EXEC: begin
          if (!w_empty) begin
            alu_func = w_head[6:4];
            alu_data = w_head[3:0];
          end
        end
        ST_RESULT: begin
          res_valid = 1'b1;
        end
        default: begin
          alu_func = FUNC_HOLD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_cmd_sequencer
// Desc   : Self-checking bench for alu_cmd_sequencer with an accumulator ALU
//          datapath model. Instance A uses CLR_ON_START=1, instance B uses 0.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Instance A (clears before each program)
  logic       Reset_b   = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_func  = 3'b111;
  logic [3:0] cmd_data  = 4'd0;
  logic       cmd_last  = 1'b0;
  logic       res_ready = 1'b0;
  logic       cmd_ready, res_valid, alu_clr_b, busy;
  logic [7:0] res_data, op_cnt;
  logic [2:0] alu_func;
  logic [3:0] alu_data;
  logic [7:0] alu_q = 8'h00;

  // Instance B (accumulator carries over between programs)
  logic       b_reset_n   = 1'b0;
  logic       b_cmd_valid = 1'b0;
  logic [2:0] b_cmd_func  = 3'b111;
  logic [3:0] b_cmd_data  = 4'd0;
  logic       b_cmd_last  = 1'b0;
  logic       b_res_ready = 1'b0;
  logic       b_cmd_ready, b_res_valid, b_alu_clr_b, b_busy;
  logic [7:0] b_res_data, b_op_cnt;
  logic [2:0] b_alu_func;
  logic [3:0] b_alu_data;
  logic [7:0] b_alu_q = 8'h00;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CLR_ON_START(1'b1)) u_dut_a (
    .Clock(Clock), .Reset_b(Reset_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_data(cmd_data), .cmd_last(cmd_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .alu_func(alu_func), .alu_data(alu_data), .alu_clr_b(alu_clr_b),
    .alu_q(alu_q), .busy(busy), .op_cnt(op_cnt)
  );

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CLR_ON_START(1'b0)) u_dut_b (
    .Clock(Clock), .Reset_b(b_reset_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_func(b_cmd_func),
    .cmd_data(b_cmd_data), .cmd_last(b_cmd_last),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data),
    .alu_func(b_alu_func), .alu_data(b_alu_data), .alu_clr_b(b_alu_clr_b),
    .alu_q(b_alu_q), .busy(b_busy), .op_cnt(b_op_cnt)
  );

  // Accumulator datapath: synchronous active-low clear, 111 holds
  function automatic logic [7:0] alu_model(input logic [7:0] q, input logic [2:0] f,
                                           input logic [3:0] d, input logic clr_b);
    logic [7:0] dx;
    dx = {4'h0, d};
    if (!clr_b) return 8'h00;
    case (f)
      3'b000:  return dx;
      3'b001:  return q + dx;
      3'b010:  return q - dx;
      3'b011:  return q & dx;
      3'b100:  return q | dx;
      3'b101:  return q << d;
      3'b110:  return q * dx;
      default: return q;
    endcase
  endfunction

  // Expected result of a program: fold its ops over the starting value
  function automatic logic [7:0] ref_result(input logic [7:0] start, input logic [7:0] prog[$]);
    logic [7:0] acc;
    acc = start;
    foreach (prog[i]) acc = alu_model(acc, prog[i][6:4], prog[i][3:0], 1'b1);
    return acc;
  endfunction

  always @(posedge Clock) begin
    alu_q   <= alu_model(alu_q, alu_func, alu_data, alu_clr_b);
    b_alu_q <= alu_model(b_alu_q, b_alu_func, b_alu_data, b_alu_clr_b);
  end

  // Cycle counter and observation of what the datapath is told to do
  int         cyc = 0;
  logic [6:0] iss_fd[$];
  int         iss_cyc[$];
  logic [7:0] iss_q[$];
  int         clr_cyc[$];
  int         rv_cnt = 0;
  int         b_clr_low = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (Reset_b && alu_func != 3'b111) begin
      iss_fd.push_back({alu_func, alu_data});
      iss_cyc.push_back(cyc);
      iss_q.push_back(alu_q);
    end
    if (Reset_b && !alu_clr_b) clr_cyc.push_back(cyc);
    if (res_valid) rv_cnt <= rv_cnt + 1;
    if (b_reset_n && !b_alu_clr_b) b_clr_low <= b_clr_low + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] e, output int pc);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_last  = e[7];
    cmd_func  = e[6:4];
    cmd_data  = e[3:0];
    while (!acc && n < 200) begin
      acc = cmd_ready;
      @(posedge Clock); #1;
      n++;
    end
    cmd_valid = 1'b0;
    pc = cyc;
    check("push_accepted", {31'b0, acc}, 1);
  endtask

  task automatic wait_result(input int hold, input bit accept, output logic [7:0] data,
                             output logic [7:0] cnt, output int rv_cyc,
                             output bit all_busy, output int unstable);
    int n;
    n = 0;
    all_busy = 1'b1;
    unstable = 0;
    while (res_valid !== 1'b1 && n < 300) begin
      all_busy &= busy;
      @(posedge Clock); #1;
      n++;
    end
    check("res_valid_seen", {31'b0, res_valid}, 1);
    all_busy &= busy;
    data   = res_data;
    cnt    = op_cnt;
    rv_cyc = cyc;
    repeat (hold) begin
      @(posedge Clock); #1;
      if (res_valid !== 1'b1 || res_data !== data) unstable++;
    end
    if (accept) begin
      res_ready = 1'b1;
      @(posedge Clock); #1;
      res_ready = 1'b0;
    end
  endtask

  initial begin
    int         pc, pc2, rvc, base, base2, k, unst, len, mism, nexp, n, rvb;
    logic [7:0] d, cnt;
    bit         ab, r;
    logic [7:0] prog[$];
    logic [7:0] burst[6];

    // ---- Reset state ----
    repeat (2) @(posedge Clock);
    #1;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    check("rst_res_valid", {31'b0, res_valid}, 0);
    check("rst_alu_clr_b", {31'b0, alu_clr_b}, 0);
    check("rst_alu_func", {29'b0, alu_func}, 7);
    check("rst_alu_data", {28'b0, alu_data}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_op_cnt", {24'b0, op_cnt}, 0);
    Reset_b = 1'b1;
    b_reset_n = 1'b1;
    #1;
    check("idle_cmd_ready", {31'b0, cmd_ready}, 1);
    check("idle_alu_clr_b", {31'b0, alu_clr_b}, 1);

    // ---- Program 3,7,14 with latency checks ----
    base = iss_fd.size();
    base2 = clr_cyc.size();
    push(8'h13, pc);
    push(8'h14, pc2);
    push(8'he2, pc2);
    wait_result(0, 1, d, cnt, rvc, ab, unst);
    check("p1_res", {24'b0, d}, 32'h0E);
    check("p1_op_cnt", {24'b0, cnt}, 3);
    check("p1_clr_cycles", clr_cyc.size() - base2, 1);
    check("p1_clr_at", clr_cyc[base2], pc + 1);
    check("p1_issue_cnt", iss_fd.size() - base, 3);
    check("p1_issue0_at", iss_cyc[base], pc + 2);
    check("p1_issue2_at", iss_cyc[base + 2], pc + 4);
    check("p1_res_valid_at", rvc, pc + 5);

    // ---- Shift program, busy over the whole program ----
    push(8'h11, pc);
    push(8'hd3, pc2);
    wait_result(2, 1, d, cnt, rvc, ab, unst);
    check("p2_res", {24'b0, d}, 32'h08);
    check("p2_busy_held", {31'b0, ab}, 1);
    check("p2_res_stable", unst, 0);
    check("p2_busy_after", {31'b0, busy}, 0);

    // ---- Burst of DEPTH+2 pushes while parked in RESULT ----
    burst = '{8'h05, 8'h11, 8'h51, 8'h22, 8'h63, 8'h94};
    push(8'h92, pc);
    wait_result(0, 0, d, cnt, rvc, ab, unst);
    check("p3a_res", {24'b0, d}, 2);
    base = iss_fd.size();
    k = 0;
    unst = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      cmd_valid = 1'b1;
      cmd_last  = burst[k][7];
      cmd_func  = burst[k][6:4];
      cmd_data  = burst[k][3:0];
      r = cmd_ready;
      @(posedge Clock); #1;
      if (r) k++;
      if (res_valid !== 1'b1 || res_data !== d) unst++;
    end
    cmd_valid = 1'b0;
    check("p3_accepted", k, DEPTH);
    check("p3_ready_low", {31'b0, cmd_ready}, 0);
    check("p3_no_issue", iss_fd.size() - base, 0);
    check("p3_res_stable", unst, 0);
    wait_result(0, 1, d, cnt, rvc, ab, unst);
    base = iss_fd.size();
    push(burst[4], pc);
    push(burst[5], pc);
    wait_result(0, 1, d, cnt, rvc, ab, unst);
    check("p3_res", {24'b0, d}, 34);
    check("p3_op_cnt", {24'b0, cnt}, 6);
    check("p3_issue_cnt", iss_fd.size() - base, 6);

    // ---- Stall between ops ----
    base = iss_fd.size();
    push(8'h15, pc);
    repeat (3) begin @(posedge Clock); #1; end
    push(8'h92, pc2);
    wait_result(0, 1, d, cnt, rvc, ab, unst);
    check("p4_res", {24'b0, d}, 7);
    check("p4_issue_cnt", iss_fd.size() - base, 2);
    check("p4_issue1_at", iss_cyc[base + 1], pc2);
    check("p4_held_q", {24'b0, iss_q[base + 1]}, 5);

    // ---- Randomized programs against the reference fold ----
    for (int p = 0; p < 10; p++) begin
      prog.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        prog.push_back({(i == len - 1), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))});
      base = iss_fd.size();
      foreach (prog[i]) begin
        push(prog[i], pc);
        n = $urandom_range(0, 2);
        repeat (n) begin @(posedge Clock); #1; end
      end
      wait_result($urandom_range(0, 2), 1, d, cnt, rvc, ab, unst);
      check("rand_res", {24'b0, d}, {24'b0, ref_result(8'h00, prog)});
      check("rand_op_cnt", {24'b0, cnt}, len);
      check("rand_res_stable", unst, 0);
      mism = 0;
      nexp = 0;
      foreach (prog[i]) begin
        if (prog[i][6:4] != 3'b111) begin
          if (base + nexp >= iss_fd.size() || iss_fd[base + nexp] !== prog[i][6:0]) mism++;
          nexp++;
        end
      end
      check("rand_issue_cnt", iss_fd.size() - base, nexp);
      check("rand_issue_seq", mism, 0);
    end

    // ---- Reset in the middle of a 4-command program ----
    rvb = rv_cnt;
    push(8'h11, pc);
    push(8'h11, pc);
    push(8'h11, pc);
    push(8'h91, pc);
    check("mr_busy_before", {31'b0, busy}, 1);
    Reset_b = 1'b0;
    #1;
    check("mr_clr_b_low", {31'b0, alu_clr_b}, 0);
    check("mr_ready_low", {31'b0, cmd_ready}, 0);
    @(posedge Clock); #1;
    Reset_b = 1'b1;
    #1;
    check("mr_ready_after", {31'b0, cmd_ready}, 1);
    check("mr_op_cnt", {24'b0, op_cnt}, 0);
    base = iss_fd.size();
    repeat (6) begin @(posedge Clock); #1; end
    check("mr_idle", {31'b0, busy}, 0);
    check("mr_no_issue", iss_fd.size() - base, 0);
    check("mr_no_result", rv_cnt - rvb, 0);

    // ---- Instance B: accumulator carries between programs ----
    for (int p = 0; p < 2; p++) begin
      check("b_cmd_ready", {31'b0, b_cmd_ready}, 1);
      b_cmd_valid = 1'b1;
      b_cmd_func  = 3'b001;
      b_cmd_data  = 4'd6;
      b_cmd_last  = 1'b1;
      @(posedge Clock); #1;
      b_cmd_valid = 1'b0;
      n = 0;
      while (b_res_valid !== 1'b1 && n < 50) begin @(posedge Clock); #1; n++; end
      check("b_res_valid", {31'b0, b_res_valid}, 1);
      check("b_res", {24'b0, b_res_data}, 6 * (p + 1));
      b_res_ready = 1'b1;
      @(posedge Clock); #1;
      b_res_ready = 1'b0;
    end
    check("b_clr_never_low", b_clr_low, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
